// File: rtl/rggen_rtl_pkg.sv
// rtl/rggen_rtl_pkg.sv - shared rggen bus access and status encodings
//
// Purpose : access-kind and response-status enumerations used by every
//           rggen bus port (hosts, adapters and the arbiter).
// Ports   : none (package).

package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_READ         = 2'b10,
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

endpackage

// File: rtl/rggen_round_robin_selector.sv
// rtl/rggen_round_robin_selector.sv - combinational round-robin requester search
//
// Purpose : picks the first set request bit at or after the pointer, searching
//           upward and wrapping from HOSTS-1 back to 0.
// Ports   : i_request  - request vector, one bit per host
//           i_pointer  - index where the search starts (highest priority)
//           o_select   - one-hot selection (all zero when nothing requests)
//           o_index    - binary index of the selected host (0 when none)

module rggen_round_robin_selector #(
    parameter int HOSTS       = 2,
    parameter int INDEX_WIDTH = (HOSTS > 1) ? $clog2(HOSTS) : 1
)(
    input  logic [HOSTS-1:0]       i_request,
    input  logic [INDEX_WIDTH-1:0] i_pointer,
    output logic [HOSTS-1:0]       o_select,
    output logic [INDEX_WIDTH-1:0] o_index
);

    always_comb begin : search
        int   candidate;
        logic found;
        candidate = 0;
        found     = 1'b0;
        o_select  = '0;
        o_index   = '0;
        for (int i = 0; i < HOSTS; i++) begin
            // Pointer is always below HOSTS, so one subtraction is enough to wrap.
            candidate = int'(i_pointer) + i;
            if (candidate >= HOSTS) begin
                candidate = candidate - HOSTS;
            end
            if (!found && i_request[candidate]) begin
                found               = 1'b1;
                o_select[candidate] = 1'b1;
                o_index             = INDEX_WIDTH'(candidate);
            end
        end
    end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// rtl/rggen_bus_arbiter.sv - round-robin arbiter sharing one rggen register bus
//
// Purpose : grants one of HOSTS upstream masters at a time onto a single
//           downstream register bus; grant is registered and held for one
//           complete transaction, pointer advances past the served host.
// Ports   : i_clk, i_rst_n (async, active-low)
//           i_valid/i_access/i_address/i_write_data/i_strobe - per-host request
//           o_ready - per-host completion; o_read_data/o_status - shared response
//           o_grant - one-hot registered grant
//           o_valid/o_access/o_address/o_write_data/o_strobe - downstream request
//           i_ready/i_read_data/i_status - downstream response
// Option  : RGGEN_BUS_ARBITER_TIMEOUT_EN adds a stall watchdog of
//           TIMEOUT_CYCLES that completes the transaction with a slave error.

module rggen_bus_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int HOSTS          = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
)(
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [HOSTS-1:0]                      i_valid,
    input  logic [HOSTS-1:0][1:0]                 i_access,
    input  logic [HOSTS-1:0][ADDRESS_WIDTH-1:0]   i_address,
    input  logic [HOSTS-1:0][BUS_WIDTH-1:0]       i_write_data,
    input  logic [HOSTS-1:0][BUS_WIDTH/8-1:0]     i_strobe,
    output logic [HOSTS-1:0]                      o_ready,
    output logic [BUS_WIDTH-1:0]                  o_read_data,
    output logic [1:0]                            o_status,
    output logic [HOSTS-1:0]                      o_grant,
    output logic                                  o_valid,
    output logic [1:0]                            o_access,
    output logic [ADDRESS_WIDTH-1:0]              o_address,
    output logic [BUS_WIDTH-1:0]                  o_write_data,
    output logic [BUS_WIDTH/8-1:0]                o_strobe,
    input  logic                                  i_ready,
    input  logic [BUS_WIDTH-1:0]                  i_read_data,
    input  logic [1:0]                            i_status
);

    localparam int HOST_INDEX_WIDTH = (HOSTS > 1) ? $clog2(HOSTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                      state;
    state_e                      state_next;
    logic [HOSTS-1:0]            grant;
    logic [HOSTS-1:0]            grant_next;
    logic [HOSTS-1:0]            select;
    logic [HOST_INDEX_WIDTH-1:0] index;
    logic [HOST_INDEX_WIDTH-1:0] index_next;
    logic [HOST_INDEX_WIDTH-1:0] pointer;
    logic [HOST_INDEX_WIDTH-1:0] pointer_next;
    logic [HOST_INDEX_WIDTH-1:0] select_index;
    logic [HOST_INDEX_WIDTH-1:0] following_index;
    logic                        valid_raw;
    logic                        timeout;
    logic                        complete;

    rggen_round_robin_selector #(
        .HOSTS       (HOSTS),
        .INDEX_WIDTH (HOST_INDEX_WIDTH)
    ) u_selector (
        .i_request (i_valid),
        .i_pointer (pointer),
        .o_select  (select),
        .o_index   (select_index)
    );

    // AND-OR mux on the one-hot grant: an empty grant yields all-zero fields.
    always_comb begin
        valid_raw    = 1'b0;
        o_access     = '0;
        o_address    = '0;
        o_write_data = '0;
        o_strobe     = '0;
        for (int h = 0; h < HOSTS; h++) begin
            if (grant[h]) begin
                valid_raw    = valid_raw    | i_valid[h];
                o_access     = o_access     | i_access[h];
                o_address    = o_address    | i_address[h];
                o_write_data = o_write_data | i_write_data[h];
                o_strobe     = o_strobe     | i_strobe[h];
            end
        end
    end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [COUNT_WIDTH-1:0] stall_count;
    logic                   stalled;

    assign stalled = valid_raw & ~i_ready;
    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle.
    assign timeout = stalled & (stall_count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_count <= '0;
        end else if (!stalled || timeout) begin
            stall_count <= '0;
        end else begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign o_read_data = timeout ? '0 : i_read_data;
    assign o_status    = timeout ? RGGEN_SLAVE_ERROR : i_status;
`else
    // Watchdog absent: this comparison is constant false.
    assign timeout     = (TIMEOUT_CYCLES < 0);
    assign o_read_data = i_read_data;
    assign o_status    = i_status;
`endif

    assign o_valid         = valid_raw & ~timeout;
    assign complete        = (o_valid & i_ready) | timeout;
    assign o_ready         = complete ? grant : '0;
    assign o_grant         = grant;
    assign following_index = (index == HOST_INDEX_WIDTH'(HOSTS - 1)) ? '0 : index + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            index   <= '0;
            pointer <= '0;
        end else begin
            state   <= state_next;
            grant   <= grant_next;
            index   <= index_next;
            pointer <= pointer_next;
        end
    end

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        index_next   = index;
        pointer_next = pointer;
        case (state)
            IDLE: begin
                if (|i_valid) begin
                    state_next = BUSY;
                    grant_next = select;
                    index_next = select_index;
                end
            end
            BUSY: begin
                if (complete) begin
                    state_next   = IDLE;
                    grant_next   = '0;
                    pointer_next = following_index;
                end else if (!valid_raw) begin
                    // Host withdrew its request: release without advancing priority.
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// tb/tb_rggen_bus_arbiter.sv - self-checking bench for rggen_bus_arbiter

module tb_rggen_bus_arbiter;
    import rggen_rtl_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [1:0]        valid;
    logic [1:0][1:0]   access;
    logic [1:0][7:0]   address;
    logic [1:0][31:0]  wdata;
    logic [1:0][3:0]   strobe;
    logic [1:0]        o_ready;
    logic [31:0]       o_read_data;
    logic [1:0]        o_status;
    logic [1:0]        o_grant;
    logic              o_valid;
    logic [1:0]        o_access;
    logic [7:0]        o_address;
    logic [31:0]       o_write_data;
    logic [3:0]        o_strobe;
    logic              dn_ready;
    logic [31:0]       dn_rdata;
    logic [1:0]        dn_status;

    int compared   = 0;
    int mismatched = 0;

    rggen_bus_arbiter #(
        .HOSTS          (2),
        .ADDRESS_WIDTH  (8),
        .BUS_WIDTH      (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (valid),
        .i_access     (access),
        .i_address    (address),
        .i_write_data (wdata),
        .i_strobe     (strobe),
        .o_ready      (o_ready),
        .o_read_data  (o_read_data),
        .o_status     (o_status),
        .o_grant      (o_grant),
        .o_valid      (o_valid),
        .o_access     (o_access),
        .o_address    (o_address),
        .o_write_data (o_write_data),
        .o_strobe     (o_strobe),
        .i_ready      (dn_ready),
        .i_read_data  (dn_rdata),
        .i_status     (dn_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        valid    = 2'b00;
        dn_ready = 1'b0;
        dn_rdata = 32'h0;
        dn_status = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_grant", {30'd0, o_grant}, 32'd0);
        check("reset_valid", {31'd0, o_valid}, 32'd0);
        check("reset_ready", {30'd0, o_ready}, 32'd0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic        dn_ready;
        logic [31:0] rdata;
        logic [1:0]  status;
        logic [1:0]  exp_grant;
        logic        exp_valid;
        logic [1:0]  exp_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] v, logic r, logic [31:0] rd, logic [1:0] st,
                                logic [1:0] g, logic ov, logic [1:0] ordy);
        vec_t t;
        t.valid = v; t.dn_ready = r; t.rdata = rd; t.status = st;
        t.exp_grant = g; t.exp_valid = ov; t.exp_ready = ordy;
        return t;
    endfunction

    logic [1:0]  exp_access;
    logic [7:0]  exp_address;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strobe;
    logic [1:0]  seq_grant [6];
    logic [1:0]  seq_ready [6];
    logic        got;
    int          busy_cycles;

    initial begin
        // Fixed per-host requests: host0 writes, host1 reads.
        access[0]  = RGGEN_WRITE;
        address[0] = 8'h10;
        wdata[0]   = 32'hA5A5_0001;
        strobe[0]  = 4'hF;
        access[1]  = RGGEN_READ;
        address[1] = 8'h04;
        wdata[1]   = 32'h1111_2222;
        strobe[1]  = 4'h0;

        // valid, dn_ready, rdata, status -> grant, o_valid, o_ready
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 2'b00)); // arbitration cycle
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,         2'b00, 2'b01, 1'b1, 2'b00)); // host0 write waits
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,         2'b00, 2'b01, 1'b1, 2'b00));
        vecs.push_back(mk(2'b01, 1'b1, 32'h0,         2'b00, 2'b01, 1'b1, 2'b01)); // completes
        vecs.push_back(mk(2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 2'b00));
        vecs.push_back(mk(2'b10, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 2'b00)); // host1 read
        vecs.push_back(mk(2'b10, 1'b1, 32'hDEAD_BEEF, 2'b00, 2'b10, 1'b1, 2'b10));
        vecs.push_back(mk(2'b00, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 2'b00));
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 2'b00)); // abandon setup
        vecs.push_back(mk(2'b01, 1'b0, 32'h0,         2'b00, 2'b01, 1'b1, 2'b00));
        vecs.push_back(mk(2'b00, 1'b0, 32'h0,         2'b00, 2'b01, 1'b0, 2'b00)); // withdrawn
        vecs.push_back(mk(2'b11, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 2'b00)); // back in IDLE
        vecs.push_back(mk(2'b11, 1'b1, 32'h0,         2'b00, 2'b01, 1'b1, 2'b01)); // host0 still favoured
        vecs.push_back(mk(2'b10, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 2'b00));
        vecs.push_back(mk(2'b10, 1'b1, 32'h1234_5678, 2'b01, 2'b10, 1'b1, 2'b10));
        vecs.push_back(mk(2'b00, 1'b1, 32'hCAFE_F00D, 2'b11, 2'b00, 1'b0, 2'b00)); // idle ready ignored

        do_reset();

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            valid     = vecs[i].valid;
            dn_ready  = vecs[i].dn_ready;
            dn_rdata  = vecs[i].rdata;
            dn_status = vecs[i].status;
            exp_access  = 2'b00;
            exp_address = 8'h00;
            exp_wdata   = 32'h0;
            exp_strobe  = 4'h0;
            for (int h = 0; h < 2; h++) begin
                if (vecs[i].exp_grant[h]) begin
                    exp_access  = access[h];
                    exp_address = address[h];
                    exp_wdata   = wdata[h];
                    exp_strobe  = strobe[h];
                end
            end
            @(negedge clk);
            check($sformatf("v%0d_grant", i),  {30'd0, o_grant},     {30'd0, vecs[i].exp_grant});
            check($sformatf("v%0d_valid", i),  {31'd0, o_valid},     {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d_ready", i),  {30'd0, o_ready},     {30'd0, vecs[i].exp_ready});
            check($sformatf("v%0d_access", i), {30'd0, o_access},    {30'd0, exp_access});
            check($sformatf("v%0d_addr", i),   {24'd0, o_address},   {24'd0, exp_address});
            check($sformatf("v%0d_wdata", i),  o_write_data,         exp_wdata);
            check($sformatf("v%0d_strobe", i), {28'd0, o_strobe},    {28'd0, exp_strobe});
            check($sformatf("v%0d_rdata", i),  o_read_data,          vecs[i].rdata);
            check($sformatf("v%0d_status", i), {30'd0, o_status},    {30'd0, vecs[i].status});
        end

        // Contention from reset with both requests held and zero-wait downstream.
        seq_grant = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        seq_ready = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        do_reset();
        valid    = 2'b11;
        dn_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rr%0d_grant", k), {30'd0, o_grant}, {30'd0, seq_grant[k]});
            check($sformatf("rr%0d_ready", k), {30'd0, o_ready}, {30'd0, seq_ready[k]});
        end
        valid    = 2'b00;
        dn_ready = 1'b0;
        @(negedge clk);

        // Reset while host1 is in BUSY; pointer is 1 beforehand.
        valid = 2'b10;
        got   = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (o_valid) got = 1'b1;
        end
        check("rst_busy_reached", {31'd0, got}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", {31'd0, o_valid}, 32'd0);
        check("rst_async_grant", {30'd0, o_grant}, 32'd0);
        check("rst_async_ready", {30'd0, o_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid = 2'b11;
        @(posedge clk);
        @(negedge clk);
        check("rst_first_grant", {30'd0, o_grant}, 32'd1);
        valid = 2'b00;
        @(negedge clk);

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
        do_reset();
        valid       = 2'b01;
        dn_rdata    = 32'h55AA_55AA;
        dn_status   = 2'b00;
        busy_cycles = 0;
        got         = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_grant == 2'b01) busy_cycles++;
            if (o_ready != 2'b00) got = 1'b1;
        end
        check("to_pulse_seen",  {31'd0, got},       32'd1);
        check("to_stall_count", busy_cycles,        32'd8);
        check("to_ready",       {30'd0, o_ready},   32'd1);
        check("to_status",      {30'd0, o_status},  {30'd0, RGGEN_SLAVE_ERROR});
        check("to_rdata",       o_read_data,        32'd0);
        check("to_valid_drop",  {31'd0, o_valid},   32'd0);
        valid = 2'b11;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("to_pointer_adv", {30'd0, o_grant},   32'd2);
        valid = 2'b00;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
